// File: rtl/decode_stage_pkg.sv
// Shared instruction-format definitions for the decode stage and its scoreboard.
// Field positions, widths and the write encoding of the dst field live here only.
package decode_stage_pkg;

    localparam int INST_W = 32;
    localparam int OPC_W  = 8;
    localparam int REG_W  = 4;
    localparam int IMM_W  = 16;

    localparam int OPC_HI    = 31;
    localparam int OPC_LO    = 28;
    localparam int RD_HI     = 27;
    localparam int RD_LO     = 24;
    localparam int RS_HI     = 23;
    localparam int RS_LO     = 20;
    localparam int FLOAT_BIT = 19;
    localparam int SRC_BIT   = 18;
    localparam int DST_HI    = 17;
    localparam int DST_LO    = 16;
    localparam int FUNC_HI   = 15;
    localparam int FUNC_LO   = 12;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    localparam logic [1:0] DST_WRITE = 2'b11;
    localparam logic       SRC_IMM   = 1'b1;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic             isfloat;
        logic             src;
        logic [1:0]       dst;
        logic             iswrite;
        logic [IMM_W-1:0] imm;
    } dec_t;

    // Immediate-form instructions carry no function nibble, so the low opcode bits are zero.
    function automatic dec_t decode_inst(input logic [INST_W-1:0] inst);
        dec_t d;
        d.rd      = inst[RD_HI:RD_LO];
        d.rs      = inst[RS_HI:RS_LO];
        d.isfloat = inst[FLOAT_BIT];
        d.src     = inst[SRC_BIT];
        d.dst     = inst[DST_HI:DST_LO];
        d.iswrite = (inst[DST_HI:DST_LO] == DST_WRITE);
        d.imm     = inst[IMM_HI:IMM_LO];
        d.opcode  = (inst[SRC_BIT] == SRC_IMM) ? {inst[OPC_HI:OPC_LO], 4'h0}
                                               : {inst[OPC_HI:OPC_LO], inst[FUNC_HI:FUNC_LO]};
        return d;
    endfunction

    function automatic logic reg_in_range(input logic [REG_W-1:0] a, input int nreg);
        return int'(a) < nreg;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register busy bits with writeback bypass on lookup; an issue-set beats a
// same-cycle writeback-clear. Addresses >= NREG never match and are ignored.
module decode_scoreboard
    import decode_stage_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [REG_W-1:0] set_rd_i,
    input  logic             clr_i,
    input  logic [REG_W-1:0] clr_rd_i,
    input  logic [REG_W-1:0] rs_addr_i,
    input  logic [REG_W-1:0] rd_addr_i,
    output logic             rs_busy_o,
    output logic             rd_busy_o,
    output logic [NREG-1:0]  busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] bypassed;

    always_comb begin
        busy_d    = busy_q;
        bypassed  = busy_q;
        rs_busy_o = 1'b0;
        rd_busy_o = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (clr_i && (clr_rd_i == REG_W'(r))) begin
                busy_d[r]   = 1'b0;
                bypassed[r] = 1'b0;
            end
            if (set_i && (set_rd_i == REG_W'(r))) begin
                busy_d[r] = 1'b1;
            end
            if (rs_addr_i == REG_W'(r)) begin
                rs_busy_o = bypassed[r];
            end
            if (rd_addr_i == REG_W'(r)) begin
                rd_busy_o = bypassed[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode stage: field decode, immediate extension, scoreboard
// hazard stalls and a valid/ready output register with flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int NREG     = 16,
    parameter int XLEN     = 32,
    parameter int IMM_SEXT = 1,
    parameter int SB_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rs,
    output logic              out_isfloat,
    output logic              out_src,
    output logic              out_iswrite,
    output logic [1:0]        out_dst,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              flush,
    output logic [NREG-1:0]   busy,
    output logic [15:0]       stall_cnt
);

    dec_t        dec;
    logic        illegal;
    logic        rs_busy;
    logic        rd_busy;
    logic        held_hit;
    logic        hazard;
    logic        accept;
    logic        issue;

    dec_t        dec_q;
    dec_t        dec_d;
    logic        illegal_q;
    logic        illegal_d;
    logic        valid_q;
    logic        valid_d;
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    assign dec     = decode_inst(in_inst);
    assign illegal = !reg_in_range(dec.rd, NREG) ||
                     (!dec.src && !reg_in_range(dec.rs, NREG));

    decode_scoreboard #(
        .NREG(NREG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_i     (issue),
        .set_rd_i  (dec_q.rd),
        .clr_i     (wb_valid),
        .clr_rd_i  (wb_rd),
        .rs_addr_i (dec.rs),
        .rd_addr_i (dec.rd),
        .rs_busy_o (rs_busy),
        .rd_busy_o (rd_busy),
        .busy_o    (busy)
    );

    // The held write has not issued yet, so its target is not busy; compare against it directly.
    always_comb begin
        held_hit = valid_q && dec_q.iswrite &&
                   ((!dec.src && (dec_q.rd == dec.rs)) ||
                    (dec.iswrite && (dec_q.rd == dec.rd)));
        hazard   = (SB_EN != 0) && in_valid &&
                   ((!dec.src && rs_busy) || (dec.iswrite && rd_busy) || held_hit);
    end

    assign in_ready = !rst && (!valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = valid_q && out_ready && !flush && dec_q.iswrite && !illegal_q;

    always_comb begin
        dec_d     = dec_q;
        illegal_d = illegal_q;
        valid_d   = valid_q;
        stall_d   = stall_q;
        if (accept) begin
            dec_d     = dec;
            illegal_d = illegal;
        end
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (in_valid && hazard && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q     <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            stall_q   <= '0;
        end else begin
            dec_q     <= dec_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_opcode  = dec_q.opcode;
    assign out_rd      = dec_q.rd;
    assign out_rs      = dec_q.rs;
    assign out_isfloat = dec_q.isfloat;
    assign out_src     = dec_q.src;
    assign out_iswrite = dec_q.iswrite;
    assign out_dst     = dec_q.dst;
    assign out_illegal = illegal_q;
    assign out_imm     = (IMM_SEXT != 0) ? XLEN'($signed(dec_q.imm)) : XLEN'(dec_q.imm);
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a field-arithmetic reference model of the stage.
module tb_decode_stage;

    localparam int NREG_T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;

    logic        in_ready, out_valid, out_isfloat, out_src, out_iswrite, out_illegal;
    logic [7:0]  out_opcode;
    logic [3:0]  out_rd, out_rs;
    logic [1:0]  out_dst;
    logic [31:0] out_imm;
    logic [NREG_T-1:0] busy;
    logic [15:0] stall_cnt;

    logic        z_in_ready, z_out_valid, z_out_isfloat, z_out_src, z_out_iswrite, z_out_illegal;
    logic [7:0]  z_out_opcode;
    logic [3:0]  z_out_rd, z_out_rs;
    logic [1:0]  z_out_dst;
    logic [31:0] z_out_imm;
    logic [15:0] z_busy;
    logic [15:0] z_stall_cnt;

    int nCompared = 0;
    int nMismatched = 0;

    bit [15:0]   mBusy;
    bit          mValid;
    logic [31:0] mInst;
    int          mStall;

    always #5 clk = ~clk;

    decode_stage #(.NREG(NREG_T), .XLEN(32), .IMM_SEXT(1), .SB_EN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs(out_rs), .out_isfloat(out_isfloat), .out_src(out_src),
        .out_iswrite(out_iswrite), .out_dst(out_dst), .out_imm(out_imm),
        .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    // Zero-extending instance without hazard stalls, sharing all inputs.
    decode_stage #(.NREG(16), .XLEN(32), .IMM_SEXT(0), .SB_EN(0)) u_dut_z (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .in_inst(in_inst),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_opcode(z_out_opcode),
        .out_rd(z_out_rd), .out_rs(z_out_rs), .out_isfloat(z_out_isfloat), .out_src(z_out_src),
        .out_iswrite(z_out_iswrite), .out_dst(z_out_dst), .out_imm(z_out_imm),
        .out_illegal(z_out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(z_busy), .stall_cnt(z_stall_cnt)
    );

    function automatic int fRd(input logic [31:0] i); return int'((i >> 24) & 32'hF); endfunction
    function automatic int fRs(input logic [31:0] i); return int'((i >> 20) & 32'hF); endfunction
    function automatic bit fSrc(input logic [31:0] i); return ((i >> 18) & 32'h1) != 0; endfunction
    function automatic int fDst(input logic [31:0] i); return int'((i >> 16) & 32'h3); endfunction
    function automatic bit fIsW(input logic [31:0] i); return fDst(i) == 3; endfunction
    function automatic bit fIllegal(input logic [31:0] i);
        return (fRd(i) >= NREG_T) || (!fSrc(i) && (fRs(i) >= NREG_T));
    endfunction

    function automatic logic [21:0] expPack(input logic [31:0] i);
        int opc = int'((i >> 28) & 32'hF) * 16;
        int fl  = int'((i >> 19) & 32'h1);
        if (!fSrc(i)) opc = opc + int'((i >> 12) & 32'hF);
        return {8'(opc), 4'(fRd(i)), 4'(fRs(i)), 1'(fl), 1'(fSrc(i)), 2'(fDst(i)),
                1'(fIsW(i)), 1'(fIllegal(i))};
    endfunction

    function automatic logic [31:0] expImm(input logic [31:0] i);
        int v = int'(i & 32'hFFFF);
        if (v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    function automatic bit mBusyEff(input int r);
        return (r < NREG_T) && mBusy[r] && !(wb_valid && (int'(wb_rd) == r));
    endfunction

    function automatic bit expHazard();
        int  rd  = fRd(in_inst);
        int  rs  = fRs(in_inst);
        bit  src = fSrc(in_inst);
        bit  wr  = fIsW(in_inst);
        int  hrd = fRd(mInst);
        if (!in_valid) return 1'b0;
        if (!src && mBusyEff(rs)) return 1'b1;
        if (wr && mBusyEff(rd)) return 1'b1;
        if (mValid && fIsW(mInst) && ((!src && hrd == rs) || (wr && hrd == rd))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit expReady();
        return !rst && (!mValid || out_ready) && !expHazard() && !flush;
    endfunction

    task automatic modelStep();
        bit acc, iss, hz;
        if (rst) begin
            mBusy = '0; mValid = 1'b0; mInst = '0; mStall = 0;
            return;
        end
        hz  = expHazard();
        acc = in_valid && expReady();
        iss = mValid && out_ready && !flush && fIsW(mInst) && !fIllegal(mInst);
        if (in_valid && hz && !flush && mStall < 65535) mStall = mStall + 1;
        if (wb_valid && int'(wb_rd) < NREG_T) mBusy[wb_rd] = 1'b0;
        if (iss) mBusy[fRd(mInst)] = 1'b1;
        if (flush) mValid = 1'b0;
        else if (acc) begin mValid = 1'b1; mInst = in_inst; end
        else if (out_ready) mValid = 1'b0;
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_inst = 32'h1507_0001; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = 4'h0; flush = 1'b0;
        #1;
        nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
        cycle(); cycle();
        nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_in_ready_late: got %b want 0", in_ready); end
        nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        nCompared++; if (busy !== '0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %h want 0", busy); end
        nCompared++; if (stall_cnt !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_stall: got %h want 0", stall_cnt); end
        nCompared++; if ({out_opcode, out_rd, out_rs, out_imm, out_illegal} !== '0) begin nMismatched++; $display("[TB] FAIL reset_data: got %h/%h/%h/%h want 0", out_opcode, out_rd, out_rs, out_imm); end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_decode();
        in_valid = 1'b1; in_inst = 32'h1234_F005; out_ready = 1'b1;
        #1;
        nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL decode_ready: got %b want 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL decode_valid: got %b want 1", out_valid); end
        nCompared++; if (out_opcode !== 8'h10) begin nMismatched++; $display("[TB] FAIL decode_opcode: got %h want 10", out_opcode); end
        nCompared++; if ({out_rd, out_rs, out_src, out_iswrite} !== {4'd2, 4'd3, 1'b1, 1'b0}) begin nMismatched++; $display("[TB] FAIL decode_fields: got rd=%0d rs=%0d src=%b wr=%b want 2 3 1 0", out_rd, out_rs, out_src, out_iswrite); end
        nCompared++; if (out_imm !== 32'hFFFF_F005) begin nMismatched++; $display("[TB] FAIL decode_imm_sext: got %h want FFFFF005", out_imm); end
        nCompared++; if (z_out_imm !== 32'h0000_F005) begin nMismatched++; $display("[TB] FAIL decode_imm_zext: got %h want 0000F005", z_out_imm); end
        cycle();
        nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL decode_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; in_inst = 32'h1507_0001; out_ready = 1'b1;
        cycle();
        in_inst = 32'h2150_3000;
        #1;
        nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL hazard_held_ready: got %b want 0", in_ready); end
        cycle();
        nCompared++; if (busy[5] !== 1'b1) begin nMismatched++; $display("[TB] FAIL hazard_busy5_set: got %b want 1", busy[5]); end
        nCompared++; if (stall_cnt !== 16'd1) begin nMismatched++; $display("[TB] FAIL hazard_stall_first: got %0d want 1", stall_cnt); end
        for (int k = 0; k < 3; k++) begin
            #1;
            nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL hazard_ready_%0d: got %b want 0", k, in_ready); end
            cycle();
            nCompared++; if (stall_cnt !== 16'(2 + k)) begin nMismatched++; $display("[TB] FAIL hazard_stall_%0d: got %0d want %0d", k, stall_cnt, 2 + k); end
        end
        wb_valid = 1'b1; wb_rd = 4'd5;
        #1;
        nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL hazard_bypass_ready: got %b want 1", in_ready); end
        cycle();
        wb_valid = 1'b0; in_valid = 1'b0;
        nCompared++; if ({out_valid, out_rs, busy[5]} !== {1'b1, 4'd5, 1'b0}) begin nMismatched++; $display("[TB] FAIL hazard_after_wb: got v=%b rs=%0d b5=%b want 1 5 0", out_valid, out_rs, busy[5]); end
        nCompared++; if (stall_cnt !== 16'd4) begin nMismatched++; $display("[TB] FAIL hazard_stall_hold: got %0d want 4", stall_cnt); end
        cycle();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_inst = 32'h4104_0011; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0; in_inst = 32'h4204_0022;
        for (int k = 0; k < 3; k++) begin
            #1;
            nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_ready_%0d: got %b want 0", k, in_ready); end
            cycle();
            nCompared++; if ({out_valid, out_rd, out_imm} !== {1'b1, 4'd1, 32'h11}) begin nMismatched++; $display("[TB] FAIL bp_hold_%0d: got v=%b rd=%0d imm=%h want 1 1 11", k, out_valid, out_rd, out_imm); end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_inst = {4'h4, 4'(2 + k), 8'h04, 16'(k)};
            #1;
            nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_ready_%0d: got %b want 1", k, in_ready); end
            cycle();
            nCompared++; if ({out_valid, out_rd} !== {1'b1, 4'(2 + k)}) begin nMismatched++; $display("[TB] FAIL b2b_out_%0d: got v=%b rd=%0d want 1 %0d", k, out_valid, out_rd, 2 + k); end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_inst = 32'h1707_0000; out_ready = 1'b1;
        cycle();
        in_inst = 32'h4104_0000; flush = 1'b1;
        #1;
        nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_ready: got %b want 0", in_ready); end
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_valid: got %b want 0", out_valid); end
        nCompared++; if (busy[7] !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_busy7: got %b want 0", busy[7]); end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_inst = 32'h3907_0000; out_ready = 1'b1;
        cycle();
        nCompared++; if ({out_illegal, out_rd} !== {1'b1, 4'd9}) begin nMismatched++; $display("[TB] FAIL illegal_rd: got ill=%b rd=%0d want 1 9", out_illegal, out_rd); end
        in_inst = 32'h31A0_0000;
        #1;
        nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL illegal_rs_ready: got %b want 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        nCompared++; if (busy !== '0) begin nMismatched++; $display("[TB] FAIL illegal_no_set: got %h want 0", busy); end
        nCompared++; if ({out_illegal, out_rs} !== {1'b1, 4'd10}) begin nMismatched++; $display("[TB] FAIL illegal_rs: got ill=%b rs=%0d want 1 10", out_illegal, out_rs); end
        cycle();
    endtask

    task automatic test_same_cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid = 1'b1; in_inst = 32'h1407_0000; out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 4'd4;
        cycle();
        nCompared++; if (z_busy[4] !== 1'b1) begin nMismatched++; $display("[TB] FAIL same_cycle_set_wins: got %b want 1", z_busy[4]); end
        nCompared++; if (busy !== mBusy[NREG_T-1:0]) begin nMismatched++; $display("[TB] FAIL same_cycle_main_busy: got %h want %h", busy, mBusy[NREG_T-1:0]); end
        cycle();
        wb_valid = 1'b0;
        nCompared++; if (z_busy[4] !== 1'b0) begin nMismatched++; $display("[TB] FAIL same_cycle_wb_clear: got %b want 0", z_busy[4]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            in_inst   = {4'($urandom), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom), 16'($urandom)};
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 4) < 2);
            wb_rd     = 4'($urandom_range(0, 9));
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            nCompared++; if (in_ready !== expReady()) begin nMismatched++; $display("[TB] FAIL rnd_ready c%0d: got %b want %b", c, in_ready, expReady()); end
            cycle();
            nCompared++; if (out_valid !== mValid) begin nMismatched++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, out_valid, mValid); end
            nCompared++; if ({out_opcode, out_rd, out_rs, out_isfloat, out_src, out_dst, out_iswrite, out_illegal} !== expPack(mInst)) begin nMismatched++; $display("[TB] FAIL rnd_fields c%0d: got %h want %h", c, {out_opcode, out_rd, out_rs, out_isfloat, out_src, out_dst, out_iswrite, out_illegal}, expPack(mInst)); end
            nCompared++; if (out_imm !== expImm(mInst)) begin nMismatched++; $display("[TB] FAIL rnd_imm c%0d: got %h want %h", c, out_imm, expImm(mInst)); end
            nCompared++; if (busy !== mBusy[NREG_T-1:0]) begin nMismatched++; $display("[TB] FAIL rnd_busy c%0d: got %h want %h", c, busy, mBusy[NREG_T-1:0]); end
            nCompared++; if (stall_cnt !== 16'(mStall)) begin nMismatched++; $display("[TB] FAIL rnd_stall c%0d: got %0d want %0d", c, stall_cnt, mStall); end
        end
        in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_hazard();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_same_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
